// File: rtl/wm8731_pkg.sv
// Shared definitions for the WM8731 configuration sequencer: register
// addresses, table entry layout, FSM states and the I2C word packer.
package wm8731_pkg;

  // WM8731 control register addresses
  localparam logic [6:0] REG_LLINE_IN  = 7'h00;  // R0  left line in
  localparam logic [6:0] REG_RLINE_IN  = 7'h01;  // R1  right line in
  localparam logic [6:0] REG_LHP_OUT   = 7'h02;  // R2  left headphone out
  localparam logic [6:0] REG_RHP_OUT   = 7'h03;  // R3  right headphone out
  localparam logic [6:0] REG_ANA_PATH  = 7'h04;  // R4  analogue audio path
  localparam logic [6:0] REG_DIG_PATH  = 7'h05;  // R5  digital audio path
  localparam logic [6:0] REG_PWR_DOWN  = 7'h06;  // R6  power down control
  localparam logic [6:0] REG_DIG_IF    = 7'h07;  // R7  digital audio interface
  localparam logic [6:0] REG_SAMPLING  = 7'h08;  // R8  sampling control
  localparam logic [6:0] REG_ACTIVE    = 7'h09;  // R9  active control
  localparam logic [6:0] REG_RESET     = 7'h0F;  // R15 software reset

  // Number of entries in the configuration table
  localparam int TABLE_LEN = 11;

  // One configuration table entry
  typedef struct packed {
    logic [6:0] reg_addr;
    logic [8:0] data;
  } cfg_entry_t;

  // Sequencer states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_ISSUE,
    ST_WAIT,
    ST_GAP,
    ST_DONE,
    ST_FAIL
  } state_t;

  // Build the 24-bit I2C write word {dev,W, reg, data[8:0]}
  function automatic logic [23:0] pack_word(input logic [6:0] dev,
                                            input logic [6:0] reg_addr,
                                            input logic [8:0] data);
    return {dev, 1'b0, reg_addr, data};
  endfunction

endpackage

// File: rtl/wm8731_cfg_rom.sv
// Fixed WM8731 power-up register table, indexed combinationally.
// Indices past the end of the table return an all-zero entry.
module wm8731_cfg_rom
  import wm8731_pkg::*;
(
  input  logic [3:0] index,
  output cfg_entry_t entry
);

  // Table lookup
  always_comb begin
    // NOTE: every combinational output gets a default first so no path through the case infers a latch.
    entry = '0;
    case (index)
      4'd0:    entry = '{REG_RESET,    9'h000};  // software reset
      4'd1:    entry = '{REG_PWR_DOWN, 9'h000};  // power up everything
      4'd2:    entry = '{REG_LLINE_IN, 9'h017};
      4'd3:    entry = '{REG_RLINE_IN, 9'h017};
      4'd4:    entry = '{REG_LHP_OUT,  9'h079};
      4'd5:    entry = '{REG_RHP_OUT,  9'h079};
      4'd6:    entry = '{REG_ANA_PATH, 9'h012};
      4'd7:    entry = '{REG_DIG_PATH, 9'h000};
      4'd8:    entry = '{REG_DIG_IF,   9'h00A};  // I2S, 24-bit, slave
      4'd9:    entry = '{REG_SAMPLING, 9'h000};
      4'd10:   entry = '{REG_ACTIVE,   9'h001};  // activate interface
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/wm8731_cfg_seq.sv
// WM8731 configuration sequencer. Walks the register table, hands one
// packed 24-bit write word at a time to the I2C master, retries on NACK or
// timeout and reports completion or failure.
module wm8731_cfg_seq
  import wm8731_pkg::*;
#(
  parameter logic [6:0] DEV_ADDR       = 7'h1A,
  parameter int         GAP_CYCLES     = 500,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter int         MAX_RETRY      = 3,
  parameter bit         AUTO_START     = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        i2c_ready,
  input  logic        i2c_done,
  input  logic        i2c_nack,
  output logic        i2c_req,
  output logic [23:0] i2c_word,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err,
  output logic [3:0]  cfg_index
);

  // One counter serves both the WAIT timeout and the inter-word gap
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam int RETRY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

  localparam logic [CNT_W-1:0]   GAP_LAST   = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRY);
  localparam logic [3:0]         IDX_LAST   = 4'(TABLE_LEN - 1);

  state_t             state, state_n;
  logic [3:0]         idx, idx_n;
  logic [RETRY_W-1:0] retry, retry_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic               retry_pend, retry_pend_n;  // current GAP precedes a re-issue
  logic               auto_pend, auto_pend_n;    // self-start still owed after reset
  logic [23:0]        word_n;
  logic               req_n, busy_n, done_n, err_n;
  logic               attempt_fail;
  cfg_entry_t         rom_entry;

  wm8731_cfg_rom u_rom (
    .index (idx),
    .entry (rom_entry)
  );

  assign cfg_index = idx;

  // A transfer attempt fails on NACK, or on timeout when no done arrived
  // (done wins over a coincident timeout)
  assign attempt_fail = i2c_done ? i2c_nack : (cnt == TMO_LAST);

  // Next-state and next-output logic
  always_comb begin
    state_n      = state;
    idx_n        = idx;
    retry_n      = retry;
    cnt_n        = cnt;
    retry_pend_n = retry_pend;
    auto_pend_n  = auto_pend;
    word_n       = i2c_word;
    req_n        = 1'b0;
    busy_n       = !(state inside {ST_IDLE, ST_DONE, ST_FAIL});
    done_n       = (state == ST_DONE);
    err_n        = (state == ST_FAIL);

    case (state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        if ((start && !cfg_busy) || auto_pend) begin
          state_n      = ST_LOAD;
          idx_n        = '0;
          retry_n      = '0;
          retry_pend_n = 1'b0;
          auto_pend_n  = 1'b0;
        end
      end

      ST_LOAD: begin
        word_n  = pack_word(DEV_ADDR, rom_entry.reg_addr, rom_entry.data);
        state_n = ST_ISSUE;
      end

      ST_ISSUE: begin
        if (i2c_ready) begin
          req_n   = 1'b1;
          cnt_n   = '0;
          state_n = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (i2c_done && !i2c_nack) begin
          retry_pend_n = 1'b0;
          cnt_n        = '0;
          state_n      = ST_GAP;
        end else if (attempt_fail) begin
          if (retry == RETRY_LAST) begin
            state_n = ST_FAIL;
          end else begin
            retry_n      = retry + 1'b1;
            retry_pend_n = 1'b1;
            cnt_n        = '0;
            state_n      = ST_GAP;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          cnt_n = '0;
          if (retry_pend) begin
            state_n = ST_LOAD;
          end else if (idx == IDX_LAST) begin
            state_n = ST_DONE;
          end else begin
            idx_n   = idx + 4'd1;
            retry_n = '0;
            state_n = ST_LOAD;
          end
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      default: state_n = ST_IDLE;
    endcase
  end

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state uses non-blocking assignments so every register samples pre-edge values;
    // all flops sit on the async reset branch, there is no memory array to leave unreset.
    if (rst) begin
      state      <= ST_IDLE;
      idx        <= '0;
      retry      <= '0;
      cnt        <= '0;
      retry_pend <= 1'b0;
      auto_pend  <= AUTO_START;
      i2c_req    <= 1'b0;
      i2c_word   <= '0;
      cfg_busy   <= 1'b0;
      cfg_done   <= 1'b0;
      cfg_err    <= 1'b0;
    end else begin
      state      <= state_n;
      idx        <= idx_n;
      retry      <= retry_n;
      cnt        <= cnt_n;
      retry_pend <= retry_pend_n;
      auto_pend  <= auto_pend_n;
      i2c_req    <= req_n;
      i2c_word   <= word_n;
      cfg_busy   <= busy_n;
      cfg_done   <= done_n;
      cfg_err    <= err_n;
    end
  end

endmodule

// File: tb/tb_wm8731_cfg_seq.sv
// Self-checking bench for wm8731_cfg_seq with a behavioural I2C master
// model that ACKs/NACKs and reports done a fixed delay after each request.
module tb_wm8731_cfg_seq;

  localparam int GAP = 500;
  localparam int TMO = 1000;
  localparam int DLY = 200;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        i2c_ready = 1'b1;
  logic        i2c_done = 1'b0;
  logic        i2c_nack = 1'b0;
  logic        i2c_req;
  logic [23:0] i2c_word;
  logic        cfg_busy, cfg_done, cfg_err;
  logic [3:0]  cfg_index;

  wm8731_cfg_seq #(
    .DEV_ADDR       (7'h1A),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO),
    .MAX_RETRY      (3),
    .AUTO_START     (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .i2c_ready (i2c_ready),
    .i2c_done  (i2c_done),
    .i2c_nack  (i2c_nack),
    .i2c_req   (i2c_req),
    .i2c_word  (i2c_word),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err),
    .cfg_index (cfg_index)
  );

  always #10 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // I2C master model state and request log
  int          cyc = 0;
  logic [23:0] req_words[$];
  int          req_cycs[$];
  int          req_wide = 0;
  bit          prev_req = 1'b0;
  bit          never_done = 1'b0;
  logic [23:0] nack_word = 24'h0;
  int          nack_left = 0;
  int          countdown = 0;
  bit          pending = 1'b0;
  bit          pend_nack = 1'b0;

  typedef struct {
    int          idx;
    logic [23:0] word;
  } vec_t;
  vec_t vecs[11];

  // I2C master model, acting on the falling edge
  always @(negedge clk) begin
    cyc++;
    i2c_done = 1'b0;
    i2c_nack = 1'b0;
    if (rst) begin
      pending = 1'b0;
    end else if (pending) begin
      countdown--;
      if (countdown == 0) begin
        pending  = 1'b0;
        i2c_done = 1'b1;
        i2c_nack = pend_nack;
      end
    end
    if (i2c_req) begin
      if (prev_req) req_wide++;
      req_words.push_back(i2c_word);
      req_cycs.push_back(cyc);
      if (!never_done) begin
        pending   = 1'b1;
        countdown = DLY;
        pend_nack = (i2c_word == nack_word) && (nack_left > 0);
        if (pend_nack) nack_left--;
      end
    end
    prev_req = i2c_req;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic check_min(input string name, input int act, input int min);
    n_checks++;
    if (act < min) $display("FAIL %s: got %0d, expected at least %0d", name, act, min);
    else n_pass++;
  endtask

  function automatic int count_word(input logic [23:0] w);
    int n = 0;
    foreach (req_words[i]) if (req_words[i] == w) n++;
    return n;
  endfunction

  function automatic int min_spacing();
    int m = 1 << 30;
    for (int i = 1; i < req_cycs.size(); i++)
      if (req_cycs[i] - req_cycs[i-1] < m) m = req_cycs[i] - req_cycs[i-1];
    return m;
  endfunction

  task automatic clear_log();
    req_words.delete();
    req_cycs.delete();
  endtask

  // start pulse, returning once done/err have had time to clear
  task automatic pulse_start();
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    @(negedge clk);
  endtask

  task automatic wait_end(input string name, input int max);
    int n = 0;
    while (!(cfg_done || cfg_err) && n < max) begin
      @(negedge clk);
      n++;
    end
    check({name, "_end_in_time"}, 32'(n < max), 32'd1);
  endtask

  task automatic wait_reqs(input string name, input int count, input int max);
    int n = 0;
    while (req_words.size() < count && n < max) begin
      @(negedge clk);
      n++;
    end
    check({name, "_reqs_in_time"}, 32'(n < max), 32'd1);
  endtask

  // Watchdog: the run must end on its own
  initial begin
    #1_800_000;
    $display("FAIL watchdog: simulation did not finish, got %0d checks", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    bit saw_req;
    int lat;

    vecs[0]  = '{0,  24'h341E00};
    vecs[1]  = '{1,  24'h340C00};
    vecs[2]  = '{2,  24'h340017};
    vecs[3]  = '{3,  24'h340217};
    vecs[4]  = '{4,  24'h340479};
    vecs[5]  = '{5,  24'h340679};
    vecs[6]  = '{6,  24'h340812};
    vecs[7]  = '{7,  24'h340A00};
    vecs[8]  = '{8,  24'h340E0A};
    vecs[9]  = '{9,  24'h341000};
    vecs[10] = '{10, 24'h341201};

    // Reset values
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {24'h0, i2c_req, cfg_busy, cfg_done, cfg_err, cfg_index}, 32'h0);
    check("reset_word", {8'h0, i2c_word}, 32'h0);

    // Auto start after reset release, always-ACK master
    rst = 1'b0;
    wait_end("t1", 20000);
    check("t1_done", cfg_done, 1);
    check("t1_err", cfg_err, 0);
    check("t1_busy", cfg_busy, 0);
    check("t1_index", cfg_index, 10);
    check("t1_req_count", req_words.size(), 11);
    for (int i = 0; i < 11; i++)
      check($sformatf("t1_word%0d", vecs[i].idx),
            (req_words.size() > vecs[i].idx) ? {8'h0, req_words[vecs[i].idx]} : 32'hDEAD,
            {8'h0, vecs[i].word});
    check_min("t1_spacing", min_spacing(), GAP + DLY);

    // Single NACK on index 8, with start-to-busy/req timing
    clear_log();
    nack_word = 24'h340E0A;
    nack_left = 1;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    check("t2_busy_edge_n", cfg_busy, 0);
    @(negedge clk);
    check("t2_busy_edge_n1", cfg_busy, 1);
    check("t2_done_cleared", cfg_done, 0);
    @(negedge clk);
    check("t2_req_edge_n2", i2c_req, 1);
    wait_end("t2", 20000);
    check("t2_done", cfg_done, 1);
    check("t2_err", cfg_err, 0);
    check("t2_req_count", req_words.size(), 12);
    check("t2_r7_twice", count_word(24'h340E0A), 2);

    // Index 2 always NACKed: four attempts then failure
    clear_log();
    nack_word = 24'h340017;
    nack_left = 100;
    pulse_start();
    wait_end("t3", 20000);
    check("t3_err", cfg_err, 1);
    check("t3_done", cfg_done, 0);
    check("t3_busy", cfg_busy, 0);
    check("t3_index", cfg_index, 2);
    repeat (3000) @(negedge clk);
    check("t3_req_count", req_words.size(), 6);
    check("t3_r0_attempts", count_word(24'h340017), 4);
    nack_left = 0;

    // Master never reports done: timeout retries then failure
    clear_log();
    never_done = 1'b1;
    pulse_start();
    wait_end("t4", 20000);
    check("t4_err", cfg_err, 1);
    check("t4_index", cfg_index, 0);
    check("t4_attempts", count_word(24'h341E00), 4);
    check_min("t4_spacing", min_spacing(), TMO + GAP);
    never_done = 1'b0;

    // i2c_ready held low; start during busy ignored
    clear_log();
    i2c_ready = 1'b0;
    pulse_start();
    saw_req = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      start = (i == 10);
      if (i2c_req) saw_req = 1'b1;
    end
    check("t5_no_req_while_not_ready", saw_req, 0);
    check("t5_busy_while_waiting", cfg_busy, 1);
    i2c_ready = 1'b1;
    @(negedge clk);
    check("t5_req_after_ready", i2c_req, 1);
    check("t5_req_word", {8'h0, i2c_word}, 32'h00341E00);
    @(negedge clk);
    check("t5_req_single_cycle", i2c_req, 0);
    wait_reqs("t5", 4, 5000);
    pulse_start();
    wait_end("t5", 20000);
    check("t5_done", cfg_done, 1);
    check("t5_req_count", req_words.size(), 11);

    // Reset in WAIT at index 5, then restart from index 0
    clear_log();
    pulse_start();
    wait_reqs("t6", 6, 10000);
    repeat (20) @(negedge clk);
    check("t6_index_before_rst", cfg_index, 5);
    rst = 1'b1;
    #1;
    check("t6_rst_ctrl", {24'h0, i2c_req, cfg_busy, cfg_done, cfg_err, cfg_index}, 32'h0);
    check("t6_rst_word", {8'h0, i2c_word}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    clear_log();
    rst = 1'b0;
    lat = 0;
    while (!i2c_req && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check("t6_restart_latency", lat, 3);
    check("t6_restart_word", {8'h0, i2c_word}, 32'h00341E00);
    check("t6_restart_index", cfg_index, 0);
    wait_end("t6", 20000);
    check("t6_done", cfg_done, 1);
    check("t6_req_count", req_words.size(), 11);

    check("req_pulse_width", req_wide, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
